// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard entries carry register fields at a fixed maximum width; the top zero-extends.
package hazard_pkg;

    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned DEPTH_DEF  = 3;
    localparam int unsigned FWD_SEL_W  = 3;

    localparam logic [FWD_SEL_W-1:0] FWD_RF    = 3'd0;
    localparam logic [FWD_SEL_W-1:0] FWD_W_SEL = 3'(DEPTH_DEF - 1);

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      wr;
        logic      load;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      rs1_used;
        logic      rs2_used;
    } sb_entry_t;

    // True when a used source register is produced by a live, writing entry.
    function automatic logic src_match(input reg_addr_t rs, input logic used,
                                       input sb_entry_t entry);
        return used && entry.v && entry.wr && (rs == entry.rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for pipeline profiling; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Hazard and forwarding controller: a valid-tagged shift scoreboard of post-decode stages
// drives F/D stalls, D/E flushes, E-operand forwarding selects and profiling counters.
module hazard_ctrl_pipe
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 3,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_valid_i,
    input  logic [REG_AW-1:0]    d_rs1_i,
    input  logic [REG_AW-1:0]    d_rs2_i,
    input  logic                 d_rs1_used_i,
    input  logic                 d_rs2_used_i,
    input  logic [REG_AW-1:0]    d_rd_i,
    input  logic                 d_wr_i,
    input  logic                 d_load_i,
    input  logic                 e_pc_src_i,
    output logic                 stall_f_o,
    output logic                 stall_d_o,
    output logic                 flush_d_o,
    output logic                 flush_e_o,
    output logic [FWD_SEL_W-1:0] fwd_a_o,
    output logic [FWD_SEL_W-1:0] fwd_b_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];
    sb_entry_t dec_entry;

    reg_addr_t d_rs1_ext;
    reg_addr_t d_rs2_ext;

    logic load_use;
    logic any_match;
    logic hz;
    logic br;

    assign d_rs1_ext = reg_addr_t'(d_rs1_i);
    assign d_rs2_ext = reg_addr_t'(d_rs2_i);

    always_comb begin
        dec_entry          = '0;
        dec_entry.v        = 1'b1;
        dec_entry.rd       = reg_addr_t'(d_rd_i);
        dec_entry.wr       = d_wr_i;
        dec_entry.load     = d_load_i;
        dec_entry.rs1      = d_rs1_ext;
        dec_entry.rs2      = d_rs2_ext;
        dec_entry.rs1_used = d_rs1_used_i;
        dec_entry.rs2_used = d_rs2_used_i;
    end

    // Decode-source dependence against every tracked stage.
    always_comb begin
        load_use  = 1'b0;
        any_match = 1'b0;
        if (d_valid_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (src_match(d_rs1_ext, d_rs1_used_i, sb_q[k]) ||
                    src_match(d_rs2_ext, d_rs2_used_i, sb_q[k])) begin
                    any_match = 1'b1;
                    if ((k == 0) && sb_q[0].load) begin
                        load_use = 1'b1;
                    end
                end
            end
        end
    end

    // With forwarding only a load in E cannot bypass; without it every producer interlocks.
    assign hz = FWD_EN ? load_use : any_match;
    assign br = e_pc_src_i && sb_q[0].v;

    assign stall_f_o = hz && !br;
    assign stall_d_o = hz && !br;
    assign flush_d_o = br;
    assign flush_e_o = br || hz;

    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (FWD_EN && sb_q[0].v) begin
            // Walk oldest to youngest so the nearest producer overwrites older ones.
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                if (src_match(sb_q[0].rs1, sb_q[0].rs1_used, sb_q[k])) begin
                    fwd_a_o = FWD_SEL_W'(k);
                end
                if (src_match(sb_q[0].rs2, sb_q[0].rs2_used, sb_q[k])) begin
                    fwd_b_o = FWD_SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        sb_d[0] = '0;
        if (d_valid_i && !stall_d_o && !flush_e_o) begin
            sb_d[0] = dec_entry;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_d_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_d_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: forwarding, interlock-only and 2-bit-counter instances share
// one decode stream; expectations come from a table, hand sequences and an age-based model.
module tb_hazard_ctrl_pipe;

    localparam int DEPTH = 3;
    localparam int NVEC  = 15;
    localparam int NRAND = 600;

    typedef struct packed {
        logic       v;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
    } din_t;

    typedef struct packed {
        logic       stall;
        logic       fd;
        logic       fe;
        logic [2:0] fa;
        logic [2:0] fb;
    } dout_t;

    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       wr;
        logic       ld;
        logic       u1;
        logic       u2;
        int         age;
    } ins_t;

    typedef struct {
        din_t  in;
        dout_t ex;
        int    scnt;
        int    fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    din_t cur = '0;

    always #5 clk = ~clk;

    logic        sf_f, sd_f, fd_f, fe_f;
    logic [2:0]  fa_f, fb_f;
    logic [15:0] sc_f, fc_f;
    logic        sf_i, sd_i, fd_i, fe_i;
    logic [2:0]  fa_i, fb_i;
    logic [15:0] sc_i, fc_i;
    logic        sf_s, sd_s, fd_s, fe_s;
    logic [2:0]  fa_s, fb_s;
    logic [1:0]  sc_s, fc_s;

    hazard_ctrl_pipe #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .d_valid_i(cur.v), .d_rs1_i(cur.rs1), .d_rs2_i(cur.rs2),
        .d_rs1_used_i(cur.u1), .d_rs2_used_i(cur.u2), .d_rd_i(cur.rd), .d_wr_i(cur.wr),
        .d_load_i(cur.ld), .e_pc_src_i(cur.br), .stall_f_o(sf_f), .stall_d_o(sd_f),
        .flush_d_o(fd_f), .flush_e_o(fe_f), .fwd_a_o(fa_f), .fwd_b_o(fb_f),
        .stall_cnt_o(sc_f), .flush_cnt_o(fc_f)
    );

    hazard_ctrl_pipe #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1'b0), .CNT_W(16)) u_il (
        .clk(clk), .rst(rst), .d_valid_i(cur.v), .d_rs1_i(cur.rs1), .d_rs2_i(cur.rs2),
        .d_rs1_used_i(cur.u1), .d_rs2_used_i(cur.u2), .d_rd_i(cur.rd), .d_wr_i(cur.wr),
        .d_load_i(cur.ld), .e_pc_src_i(cur.br), .stall_f_o(sf_i), .stall_d_o(sd_i),
        .flush_d_o(fd_i), .flush_e_o(fe_i), .fwd_a_o(fa_i), .fwd_b_o(fb_i),
        .stall_cnt_o(sc_i), .flush_cnt_o(fc_i)
    );

    hazard_ctrl_pipe #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .d_valid_i(cur.v), .d_rs1_i(cur.rs1), .d_rs2_i(cur.rs2),
        .d_rs1_used_i(cur.u1), .d_rs2_used_i(cur.u2), .d_rd_i(cur.rd), .d_wr_i(cur.wr),
        .d_load_i(cur.ld), .e_pc_src_i(cur.br), .stall_f_o(sf_s), .stall_d_o(sd_s),
        .flush_d_o(fd_s), .flush_e_o(fe_s), .fwd_a_o(fa_s), .fwd_b_o(fb_s),
        .stall_cnt_o(sc_s), .flush_cnt_o(fc_s)
    );

    int n_chk  = 0;
    int n_fail = 0;

    ins_t q_fwd[$];
    ins_t q_il[$];
    int   ms_f, mf_f, ms_i, mf_i;
    vec_t tbl[NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_set(input string tag, input logic sf, input logic sd, input logic fd,
                           input logic fe, input logic [2:0] fa, input logic [2:0] fb,
                           input dout_t e);
        chk({tag, " stall_f"}, int'(sf), int'(e.stall));
        chk({tag, " stall_d"}, int'(sd), int'(e.stall));
        chk({tag, " flush_d"}, int'(fd), int'(e.fd));
        chk({tag, " flush_e"}, int'(fe), int'(e.fe));
        chk({tag, " fwd_a"}, int'(fa), int'(e.fa));
        chk({tag, " fwd_b"}, int'(fb), int'(e.fb));
    endtask

    function automatic din_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic wr, input logic ld,
                                input logic br);
        din_t d;
        d.v = v; d.rs1 = 4'(rs1); d.u1 = u1; d.rs2 = 4'(rs2); d.u2 = u2;
        d.rd = 4'(rd); d.wr = wr; d.ld = ld; d.br = br;
        return d;
    endfunction

    function automatic dout_t mx(input logic st, input logic fd, input logic fe,
                                 input int fa, input int fb);
        dout_t o;
        o.stall = st; o.fd = fd; o.fe = fe; o.fa = 3'(fa); o.fb = 3'(fb);
        return o;
    endfunction

    // Reference: in-flight instructions tagged by age since issue (0 = E); they retire at DEPTH.
    function automatic dout_t model_out(input ins_t q[$], input bit fwd_en, input din_t d);
        dout_t o;
        ins_t  e;
        bit    e_ok, hz, br;
        int    best_a, best_b;
        o = '0; e = '0; e_ok = 0; hz = 0; best_a = 0; best_b = 0;
        foreach (q[i]) if (q[i].age == 0) begin e = q[i]; e_ok = 1; end
        br = d.br && e_ok;
        if (d.v) begin
            foreach (q[i]) begin
                if (q[i].wr && ((d.u1 && d.rs1 == q[i].rd) || (d.u2 && d.rs2 == q[i].rd))) begin
                    if (!fwd_en || (q[i].age == 0 && q[i].ld)) hz = 1;
                end
            end
        end
        o.stall = hz && !br;
        o.fd    = br;
        o.fe    = br || hz;
        if (fwd_en && e_ok) begin
            foreach (q[i]) begin
                if (q[i].age >= 1 && q[i].wr) begin
                    if (e.u1 && e.rs1 == q[i].rd && (best_a == 0 || q[i].age < best_a))
                        best_a = q[i].age;
                    if (e.u2 && e.rs2 == q[i].rd && (best_b == 0 || q[i].age < best_b))
                        best_b = q[i].age;
                end
            end
            o.fa = 3'(best_a);
            o.fb = 3'(best_b);
        end
        return o;
    endfunction

    function automatic ins_t to_ins(input din_t d);
        ins_t n;
        n.rd = d.rd; n.rs1 = d.rs1; n.rs2 = d.rs2; n.wr = d.wr; n.ld = d.ld;
        n.u1 = d.u1; n.u2 = d.u2; n.age = 0;
        return n;
    endfunction

    task automatic model_clock();
        dout_t of, oi;
        if (rst) begin
            q_fwd.delete(); q_il.delete();
            ms_f = 0; mf_f = 0; ms_i = 0; mf_i = 0;
        end else begin
            of = model_out(q_fwd, 1'b1, cur);
            oi = model_out(q_il, 1'b0, cur);
            ms_f += int'(of.stall); mf_f += int'(of.fd);
            ms_i += int'(oi.stall); mf_i += int'(oi.fd);
            foreach (q_fwd[i]) q_fwd[i].age = q_fwd[i].age + 1;
            foreach (q_il[i]) q_il[i].age = q_il[i].age + 1;
            while (q_fwd.size() > 0 && q_fwd[0].age >= DEPTH) void'(q_fwd.pop_front());
            while (q_il.size() > 0 && q_il[0].age >= DEPTH) void'(q_il.pop_front());
            if (cur.v && !of.fe) q_fwd.push_back(to_ins(cur));
            if (cur.v && !oi.fe) q_il.push_back(to_ins(cur));
        end
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        cur = '0;
        rst = 1'b1;
        cycle_end();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dout_t eo;
        din_t  ldr, rdr;
        int    sat;

        // D-stage inputs per cycle from reset, with the outputs that cycle must show.
        tbl[0]  = '{mk(1,  5, 1,  6, 1,  1, 1, 0, 0), mx(0, 0, 0, 0, 0), 0, 0};
        tbl[1]  = '{mk(1,  1, 1,  8, 1,  7, 1, 0, 0), mx(0, 0, 0, 0, 0), 0, 0};
        tbl[2]  = '{mk(1, 10, 1,  1, 1,  9, 1, 0, 0), mx(0, 0, 0, 1, 0), 0, 0};
        tbl[3]  = '{mk(1, 11, 1,  0, 0,  2, 1, 1, 0), mx(0, 0, 0, 0, 2), 0, 0};
        tbl[4]  = '{mk(1, 13, 1,  2, 1, 12, 1, 0, 0), mx(1, 0, 1, 0, 0), 0, 0};
        tbl[5]  = '{mk(1, 13, 1,  2, 1, 12, 1, 0, 0), mx(0, 0, 0, 0, 0), 1, 0};
        tbl[6]  = '{mk(0,  0, 0,  0, 0,  0, 0, 0, 0), mx(0, 0, 0, 0, 2), 1, 0};
        tbl[7]  = '{mk(1,  1, 1,  0, 0,  3, 1, 1, 0), mx(0, 0, 0, 0, 0), 1, 0};
        tbl[8]  = '{mk(1,  3, 1,  0, 0,  4, 1, 0, 1), mx(0, 1, 1, 0, 0), 1, 0};
        tbl[9]  = '{mk(1, 14, 1, 15, 1,  4, 1, 0, 1), mx(0, 0, 0, 0, 0), 1, 1};
        tbl[10] = '{mk(1, 14, 1,  0, 0,  4, 1, 0, 0), mx(0, 0, 0, 0, 0), 1, 1};
        tbl[11] = '{mk(1,  4, 1,  4, 1,  5, 1, 0, 0), mx(0, 0, 0, 0, 0), 1, 1};
        tbl[12] = '{mk(0,  0, 0,  0, 0,  0, 0, 0, 0), mx(0, 0, 0, 1, 1), 1, 1};
        tbl[13] = '{mk(1,  5, 0,  5, 0,  6, 1, 0, 0), mx(0, 0, 0, 0, 0), 1, 1};
        tbl[14] = '{mk(0,  0, 0,  0, 0,  0, 0, 0, 0), mx(0, 0, 0, 0, 0), 1, 1};

        do_reset();
        @(negedge clk);
        chk_set("reset", sf_f, sd_f, fd_f, fe_f, fa_f, fb_f, mx(0, 0, 0, 0, 0));
        chk("reset stall_cnt", int'(sc_f), 0);
        chk("reset flush_cnt", int'(fc_f), 0);
        #1;

        for (int r = 0; r < NVEC; r++) begin
            cur = tbl[r].in;
            @(negedge clk);
            chk_set($sformatf("vec%0d", r), sf_f, sd_f, fd_f, fe_f, fa_f, fb_f, tbl[r].ex);
            chk($sformatf("vec%0d stall_cnt", r), int'(sc_f), tbl[r].scnt);
            chk($sformatf("vec%0d flush_cnt", r), int'(fc_f), tbl[r].fcnt);
            cycle_end();
        end

        // Interlock-only: dependent instruction waits until the producer leaves W.
        do_reset();
        cur = mk(1, 1, 1, 2, 1, 3, 1, 0, 0);
        @(negedge clk);
        chk("il first stall_d", int'(sd_i), 0);
        cycle_end();
        cur = mk(1, 3, 1, 0, 0, 6, 1, 0, 0);
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            chk($sformatf("il hold%0d stall_f", c), int'(sf_i), 1);
            chk($sformatf("il hold%0d stall_d", c), int'(sd_i), 1);
            chk($sformatf("il hold%0d flush_e", c), int'(fe_i), 1);
            chk($sformatf("il hold%0d flush_d", c), int'(fd_i), 0);
            if (c == 0) chk("fwd dep no stall", int'(sd_f), 0);
            if (c == 1) chk("fwd dep fwd_a M", int'(fa_f), 1);
            cycle_end();
        end
        @(negedge clk);
        chk("il release stall_d", int'(sd_i), 0);
        chk("il stall_cnt", int'(sc_i), 3);
        cycle_end();

        // Reset while a stall is active drops the pending hazard.
        do_reset();
        cur = mk(1, 1, 1, 2, 1, 3, 1, 0, 0);
        cycle_end();
        cur = mk(1, 3, 1, 0, 0, 6, 1, 0, 0);
        @(negedge clk);
        chk("pre-rst stall_d", int'(sd_i), 1);
        cycle_end();
        rst = 1'b1;
        cycle_end();
        rst = 1'b0;
        @(negedge clk);
        chk_set("post-rst", sf_i, sd_i, fd_i, fe_i, fa_i, fb_i, mx(0, 0, 0, 0, 0));
        chk("post-rst stall_cnt", int'(sc_i), 0);
        chk("post-rst flush_cnt", int'(fc_i), 0);
        cycle_end();

        // Five load-use stalls against a 2-bit counter.
        do_reset();
        ldr = mk(1, 7, 1, 0, 0, 2, 1, 1, 0);
        rdr = mk(1, 2, 1, 0, 0, 8, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cur = ldr;
            cycle_end();
            cur = rdr;
            @(negedge clk);
            chk($sformatf("sat iter%0d stall_d", i), int'(sd_s), 1);
            cycle_end();
            @(negedge clk);
            chk($sformatf("sat iter%0d released", i), int'(sd_s), 0);
            cycle_end();
        end
        cur = '0;
        @(negedge clk);
        chk("sat stall_cnt", int'(sc_s), 3);
        chk("wide stall_cnt", int'(sc_f), 5);
        cycle_end();

        // Randomized stream checked against the age model.
        do_reset();
        for (int n = 0; n < NRAND; n++) begin
            din_t r;
            r.v   = ($urandom_range(0, 99) < 85);
            r.rs1 = 4'($urandom_range(0, 3));
            r.u1  = ($urandom_range(0, 3) != 0);
            r.rs2 = 4'($urandom_range(0, 3));
            r.u2  = ($urandom_range(0, 3) != 0);
            r.rd  = 4'($urandom_range(0, 3));
            r.wr  = ($urandom_range(0, 4) != 0);
            r.ld  = ($urandom_range(0, 9) < 3);
            r.br  = ($urandom_range(0, 9) == 0);
            cur = r;
            @(negedge clk);
            eo = model_out(q_fwd, 1'b1, cur);
            chk_set($sformatf("rnd%0d fwd", n), sf_f, sd_f, fd_f, fe_f, fa_f, fb_f, eo);
            eo = model_out(q_il, 1'b0, cur);
            chk_set($sformatf("rnd%0d il", n), sf_i, sd_i, fd_i, fe_i, fa_i, fb_i, eo);
            chk($sformatf("rnd%0d fwd stall_cnt", n), int'(sc_f), ms_f);
            chk($sformatf("rnd%0d fwd flush_cnt", n), int'(fc_f), mf_f);
            chk($sformatf("rnd%0d il stall_cnt", n), int'(sc_i), ms_i);
            chk($sformatf("rnd%0d il flush_cnt", n), int'(fc_i), mf_i);
            sat = (ms_f > 3) ? 3 : ms_f;
            chk($sformatf("rnd%0d sat stall_cnt", n), int'(sc_s), sat);
            sat = (mf_f > 3) ? 3 : mf_f;
            chk($sformatf("rnd%0d sat flush_cnt", n), int'(fc_s), sat);
            cycle_end();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Parametrised hazard and forwarding controller for the pipelined reverb core.
- Tracks in-flight destination registers across the post-decode stages (E, M, W, …) in a valid-tagged shift scoreboard.
- Issues fetch/decode stalls, decode/execute flushes and per-operand forwarding selects, and counts stall and flush events for profiling.
- Sits beside the Fetch/Decode/Execute datapath; it drives the enables and clears of the inter-stage pipeline registers.

Parameters:
- REG_AW, 4, register-address width (16 architectural registers).
- DEPTH, 3, number of tracked stages after decode: index 0 = E, 1 = M, … DEPTH-1 = W. Legal range 2..6.
- FWD_EN, 1, 1 = forwarding enabled; 0 = interlock-only mode.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- d_valid  in  1  decode stage holds a real instruction
- d_rs1, d_rs2  in  REG_AW  decode source registers
- d_rs1_used, d_rs2_used  in  1  source register is actually read
- d_rd  in  REG_AW  decode destination register
- d_wr  in  1  instruction writes d_rd
- d_load  in  1  instruction is a memory load
- e_pc_src  in  1  branch taken, resolved in E
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  insert bubble into D/E register
- fwd_a, fwd_b  out  3  E-operand source: 0 = register file, k = stage k result (1..DEPTH-1)
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Scoreboard entry per stage: {v, rd, wr, load, rs1, rs2, rs1_used, rs2_used}. Rising-edge registered.
- Advance every cycle, with no global stall beyond E:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= decode fields when d_valid && !stall_d && !flush_e; otherwise a bubble (v = 0).
- Match: valid source (rsX_used) equals entry[k].rd, with entry[k].v && entry[k].wr.
- Hazard, FWD_EN=1: load-use only. A decode source matches entry[0] with entry[0].load → hz = 1 for exactly one cycle.
- Hazard, FWD_EN=0: a decode source matches any entry k in 0..DEPTH-1 → hz = 1 until that entry retires.
- Branch: e_pc_src && entry[0].v → br = 1. An e_pc_src with entry[0].v = 0 is ignored.
- Outputs (combinational from scoreboard and decode inputs):
  - stall_f = stall_d = hz && !br.
  - flush_d = br.
  - flush_e = br || hz.
- Flush has priority over stall. Simultaneous branch and load-use → flush only, no stall.
- Forwarding (FWD_EN=1): fwd_a/fwd_b compare entry[0].rs1/rs2 against entries 1..DEPTH-1. The smallest matching k wins (youngest value). No match, unused source, or entry[0].v = 0 → 0. FWD_EN=0 → always 0.
- Counters:
  - stall_cnt increments on each cycle stall_d = 1; flush_cnt on each cycle flush_d = 1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Reset (rst sampled high at an edge): all entries v = 0; counters 0. All outputs then read 0: stall/flush 0, fwd 0.
- Reset mid-stall or mid-flush: the pending hazard is dropped and the next cycle behaves as empty.
- A write to the same rd from several in-flight entries is resolved by youngest-wins.
- Latency: hazard/flush outputs are same-cycle combinational; scoreboard update is 1 cycle.

Decomposition:
- Shared package hazard_pkg:
  - typedef sb_entry_t (the struct above);
  - constants FWD_RF = 0, FWD_W_SEL = DEPTH-1;
  - function src_match(rs, used, entry).
- One natural sub-module sat_counter (CNT_W parameter, inc, rst), instantiated twice.

Test Plan:
1. ADD r1 in E, SUB uses r1 in D, FWD_EN=1 → no stall. Next cycle fwd_a = 1 (M); cycle after, for a second dependent instruction, fwd = 2 (W).
2. LDR r2 in E, ADD reads r2 in D → stall_f = stall_d = flush_e = 1 for exactly 1 cycle, then fwd_b = 2. stall_cnt = 1.
3. FWD_EN=0, ADD r3 followed by a dependent instruction → stall held 3 cycles (DEPTH) until r3 leaves W. stall_cnt = 3.
4. e_pc_src = 1 together with a load-use hazard → flush_d = flush_e = 1, stall = 0. flush_cnt = 1; the bubble appears in E next cycle.
5. Two in-flight writes to r4 (M and W) while E reads r4 → fwd_a = 1 (youngest).
6. rst asserted during an active stall → next cycle all outputs 0 and counters 0. CNT_W=2 with 5 stalls → stall_cnt = 3 (saturated).
